// File: rtl/pulse_stats_tracker_pkg.sv
// Shared constants, FSM encoding and arithmetic helpers for the pulse statistics tracker.
package pulse_stats_tracker_pkg;

  localparam int unsigned PST_HIST_DEPTH = 600;
  localparam int unsigned PST_ADDR_W     = 10;
  localparam int unsigned PST_DIV_MAX    = 7;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WRITE   = 2'd1;
  localparam logic [1:0] ST_SCAN    = 2'd2;
  localparam logic [1:0] ST_PUBLISH = 2'd3;

  function automatic logic [15:0] sat16(input logic [31:0] v);
    return (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  function automatic logic [7:0] clamp_shift(input logic [7:0] div, input int unsigned lim);
    return ({24'd0, div} > lim) ? lim[7:0] : div;
  endfunction

endpackage

// File: rtl/pulse_stats_tracker_hist_ram.sv
// History store: simple dual-port RAM, one write port, registered read port.
module pulse_hist_ram
  import pulse_stats_tracker_pkg::*;
#(
  parameter int unsigned DEPTH = PST_HIST_DEPTH,
  parameter int unsigned AW    = PST_ADDR_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr[IW-1:0]] <= wdata;
    if (re) rdata <= mem[raddr[IW-1:0]];
  end

endmodule

// File: rtl/pulse_stats_tracker.sv
// Scales incoming pulse counts, keeps a ring history and publishes latest/sum/max/min.
module pulse_stats_tracker
  import pulse_stats_tracker_pkg::*;
#(
  parameter int unsigned HIST_DEPTH = PST_HIST_DEPTH,
  parameter int unsigned DIV_MAX    = PST_DIV_MAX
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        iPause,
  input  logic        iClear,
  input  logic        iSample_Valid,
  input  logic [31:0] iSample,
  input  logic [7:0]  iGain_Divider,
  output logic        oData_Update,
  output logic [31:0] oPulse_Counter,
  output logic [31:0] oPulseCounter_Accumulated,
  output logic [15:0] oMaxPulseCounter,
  output logic [15:0] oMinPulseCounter,
  output logic [9:0]  oFill_Count,
  output logic        oBusy,
  output logic        oOverrun
);

  localparam int unsigned AW = PST_ADDR_W;
  localparam logic [AW-1:0] LAST_ADDR = AW'(HIST_DEPTH - 1);
  localparam logic [AW-1:0] FULL_FILL = AW'(HIST_DEPTH);

  logic [1:0]    state;
  logic [AW-1:0] wptr, fill, raddr;
  logic [31:0]   acc, cur, pend_data, src, scaled;
  logic          pend_valid, rvalid;
  logic [15:0]   run_max, run_min, ram_q, fin_max, fin_min;
  logic          live, accept, park, park_ok, drop, rd_en, ram_we;

  always_comb begin
    live    = en && !iClear && !iPause;
    accept  = live && (state == ST_IDLE) && (pend_valid || iSample_Valid);
    // A strobe is parked unless it is the one being taken straight from IDLE.
    park    = live && iSample_Valid && !((state == ST_IDLE) && !pend_valid);
    park_ok = park && (!pend_valid || accept);
    drop    = park && pend_valid && !accept;
    src     = pend_valid ? pend_data : iSample;
    scaled  = src >> clamp_shift(iGain_Divider, DIV_MAX);
    rd_en   = (state == ST_SCAN) && (raddr < fill);
    ram_we  = (state == ST_WRITE);
    fin_max = (ram_q > run_max) ? ram_q : run_max;
    fin_min = (ram_q < run_min) ? ram_q : run_min;
    oBusy   = (state != ST_IDLE);
  end

  pulse_hist_ram #(
    .DEPTH (HIST_DEPTH),
    .AW    (AW)
  ) u_hist (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wptr),
    .wdata (sat16(cur)),
    .re    (rd_en),
    .raddr (raddr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                     <= ST_IDLE;
      wptr                      <= '0;
      fill                      <= '0;
      raddr                     <= '0;
      acc                       <= '0;
      cur                       <= '0;
      pend_valid                <= 1'b0;
      pend_data                 <= '0;
      rvalid                    <= 1'b0;
      run_max                   <= '0;
      run_min                   <= '0;
      oData_Update              <= 1'b0;
      oPulse_Counter            <= '0;
      oPulseCounter_Accumulated <= '0;
      oMaxPulseCounter          <= '0;
      oMinPulseCounter          <= '0;
      oFill_Count               <= '0;
      oOverrun                  <= 1'b0;
    end else if (!en || iClear) begin
      state                     <= ST_IDLE;
      wptr                      <= '0;
      fill                      <= '0;
      raddr                     <= '0;
      acc                       <= '0;
      cur                       <= '0;
      pend_valid                <= 1'b0;
      pend_data                 <= '0;
      rvalid                    <= 1'b0;
      run_max                   <= '0;
      run_min                   <= '0;
      oData_Update              <= 1'b0;
      oPulse_Counter            <= '0;
      oPulseCounter_Accumulated <= '0;
      oMaxPulseCounter          <= '0;
      oMinPulseCounter          <= '0;
      oFill_Count               <= '0;
      oOverrun                  <= 1'b0;
    end else begin
      oData_Update <= 1'b0;
      if (drop) oOverrun <= 1'b1;

      if (park_ok) begin
        pend_valid <= 1'b1;
        pend_data  <= iSample;
      end else if (accept && pend_valid) begin
        pend_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            cur   <= scaled;
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          wptr    <= (wptr == LAST_ADDR) ? '0 : wptr + 1'b1;
          fill    <= (fill == FULL_FILL) ? fill : fill + 1'b1;
          acc     <= sat_add32(acc, cur);
          raddr   <= '0;
          rvalid  <= 1'b0;
          run_max <= '0;
          run_min <= '1;
          state   <= ST_SCAN;
        end
        ST_SCAN: begin
          rvalid <= rd_en;
          if (rd_en) raddr <= raddr + 1'b1;
          if (rvalid) begin
            run_max <= fin_max;
            run_min <= fin_min;
          end
          // Outputs load on the edge into PUBLISH so they are stable while the strobe is high.
          if (rvalid && !rd_en) begin
            oPulse_Counter            <= cur;
            oPulseCounter_Accumulated <= acc;
            oMaxPulseCounter          <= fin_max;
            oMinPulseCounter          <= fin_min;
            oFill_Count               <= 10'(fill);
            oData_Update              <= 1'b1;
            state                     <= ST_PUBLISH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_stats_tracker.sv
// Directed self-checking bench for pulse_stats_tracker using immediate assertions.
module tb_pulse_stats_tracker;

  // A shallow history keeps the ring-wrap scenario short.
  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        iPause = 1'b0;
  logic        iClear = 1'b0;
  logic        iSample_Valid = 1'b0;
  logic [31:0] iSample = '0;
  logic [7:0]  iGain_Divider = '0;
  logic        oData_Update;
  logic [31:0] oPulse_Counter;
  logic [31:0] oPulseCounter_Accumulated;
  logic [15:0] oMaxPulseCounter;
  logic [15:0] oMinPulseCounter;
  logic [9:0]  oFill_Count;
  logic        oBusy;
  logic        oOverrun;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  pulse_stats_tracker #(
    .HIST_DEPTH (DEPTH),
    .DIV_MAX    (7)
  ) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .en                        (en),
    .iPause                    (iPause),
    .iClear                    (iClear),
    .iSample_Valid             (iSample_Valid),
    .iSample                   (iSample),
    .iGain_Divider             (iGain_Divider),
    .oData_Update              (oData_Update),
    .oPulse_Counter            (oPulse_Counter),
    .oPulseCounter_Accumulated (oPulseCounter_Accumulated),
    .oMaxPulseCounter          (oMaxPulseCounter),
    .oMinPulseCounter          (oMinPulseCounter),
    .oFill_Count               (oFill_Count),
    .oBusy                     (oBusy),
    .oOverrun                  (oOverrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_stats(input string tag, input logic [31:0] pulse, input logic [31:0] acc,
                             input logic [15:0] mx, input logic [15:0] mn, input logic [9:0] fill);
    check({tag, "_pulse"}, oPulse_Counter, pulse);
    check({tag, "_acc"},   oPulseCounter_Accumulated, acc);
    check({tag, "_max"},   32'(oMaxPulseCounter), 32'(mx));
    check({tag, "_min"},   32'(oMinPulseCounter), 32'(mn));
    check({tag, "_fill"},  32'(oFill_Count), 32'(fill));
  endtask

  // Called at a negedge; returns at the first negedge after the accepting edge.
  task automatic strobe(input logic [31:0] s, input logic [7:0] d);
    iSample_Valid = 1'b1;
    iSample       = s;
    iGain_Divider = d;
    @(negedge clk);
    iSample_Valid = 1'b0;
  endtask

  task automatic wait_update(output int lat);
    lat = 1;
    while (!oData_Update && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    check("update_seen", 32'(oData_Update), 32'd1);
  endtask

  task automatic send_wait(input string tag, input logic [31:0] s, input logic [7:0] d,
                           input int exp_lat);
    int lat;
    strobe(s, d);
    wait_update(lat);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    @(negedge clk);
    check({tag, "_pulse_width"}, 32'(oData_Update), 32'd0);
  endtask

  task automatic watch(input int cycles, output int ups);
    ups = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (oData_Update) ups++;
    end
  endtask

  task automatic pulse_clear();
    iClear = 1'b1;
    @(negedge clk);
    iClear = 1'b0;
  endtask

  initial begin
    int ups;

    // Reset state
    repeat (3) @(negedge clk);
    check_stats("reset", 32'd0, 32'd0, 16'd0, 16'd0, 10'd0);
    check("reset_busy", 32'(oBusy), 32'd0);
    check("reset_overrun", 32'(oOverrun), 32'd0);
    check("reset_update", 32'(oData_Update), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Divider 2: 100,40,400 -> 25,10,100
    send_wait("div2_a", 32'd100, 8'd2, 4);
    send_wait("div2_b", 32'd40,  8'd2, 5);
    send_wait("div2_c", 32'd400, 8'd2, 6);
    check_stats("div2", 32'd100, 32'd135, 16'd100, 16'd10, 10'd3);

    // Divider clamped to DIV_MAX
    pulse_clear();
    check_stats("clear0", 32'd0, 32'd0, 16'd0, 16'd0, 10'd0);
    send_wait("clamp", 32'd1280, 8'd200, 4);
    check("clamp_pulse", oPulse_Counter, 32'd10);
    send_wait("div3", 32'd1280, 8'd3, 5);
    check_stats("div3", 32'd160, 32'd170, 16'd160, 16'd10, 10'd2);

    // Ring wrap: DEPTH+1 samples of value k, oldest (1) overwritten
    pulse_clear();
    for (int k = 1; k <= DEPTH; k++) begin
      strobe(32'(k), 8'd0);
      wait_update(ups);
      @(negedge clk);
    end
    check("ring_fill_pre", 32'(oFill_Count), 32'(DEPTH));
    send_wait("ring_last", 32'(DEPTH + 1), 8'd0, DEPTH + 3);
    check_stats("ring", 32'(DEPTH + 1), 32'((DEPTH + 1) * (DEPTH + 2) / 2),
                16'(DEPTH + 1), 16'd2, 10'(DEPTH));

    // Saturation of stored point and accumulator
    pulse_clear();
    send_wait("sat_a", 32'h0003_0000, 8'd0, 4);
    check_stats("sat_a", 32'h0003_0000, 32'h0003_0000, 16'hFFFF, 16'hFFFF, 10'd1);
    send_wait("sat_b", 32'hFFFF_FFFF, 8'd0, 5);
    check("sat_b_acc", oPulseCounter_Accumulated, 32'hFFFF_FFFF);
    send_wait("sat_c", 32'hFFFF_FFFF, 8'd0, 6);
    check_stats("sat_c", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, 10'd3);

    // Three back-to-back strobes: process, pend, drop
    pulse_clear();
    iSample_Valid = 1'b1;
    iGain_Divider = 8'd0;
    iSample = 32'd8;
    @(negedge clk);
    iSample = 32'd16;
    @(negedge clk);
    iSample = 32'd32;
    @(negedge clk);
    iSample_Valid = 1'b0;
    watch(60, ups);
    check("ovr_updates", 32'(ups), 32'd2);
    check("ovr_flag", 32'(oOverrun), 32'd1);
    check_stats("ovr", 32'd16, 32'd24, 16'd16, 16'd8, 10'd2);

    // Clear in the middle of a scan
    strobe(32'd9, 8'd0);
    @(negedge clk);
    @(negedge clk);
    ups = oData_Update ? 1 : 0;
    iClear = 1'b1;
    @(negedge clk);
    iClear = 1'b0;
    check_stats("midclr", 32'd0, 32'd0, 16'd0, 16'd0, 10'd0);
    check("midclr_busy", 32'(oBusy), 32'd0);
    check("midclr_overrun", 32'(oOverrun), 32'd0);
    begin
      int more;
      watch(20, more);
      ups += more;
    end
    check("midclr_updates", 32'(ups), 32'd0);
    send_wait("after_clr", 32'd5, 8'd0, 4);
    check_stats("after_clr", 32'd5, 32'd5, 16'd5, 16'd5, 10'd1);

    // Pause: strobes neither accepted nor held
    iPause = 1'b1;
    ups = 0;
    for (int i = 0; i < 5; i++) begin
      iSample_Valid = 1'b1;
      iSample = 32'(1000 + i);
      @(negedge clk);
      iSample_Valid = 1'b0;
      @(negedge clk);
      if (oData_Update) ups++;
    end
    begin
      int more;
      watch(10, more);
      ups += more;
    end
    iPause = 1'b0;
    begin
      int more;
      watch(10, more);
      ups += more;
    end
    check("pause_updates", 32'(ups), 32'd0);
    check_stats("pause", 32'd5, 32'd5, 16'd5, 16'd5, 10'd1);
    check("pause_busy", 32'(oBusy), 32'd0);
    send_wait("unpause", 32'd7, 8'd0, 5);
    check_stats("unpause", 32'd7, 32'd12, 16'd7, 16'd5, 10'd2);

    // en=0 mid-scan abandons the scan and clears state
    strobe(32'd3, 8'd0);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    check_stats("en0", 32'd0, 32'd0, 16'd0, 16'd0, 10'd0);
    check("en0_busy", 32'(oBusy), 32'd0);
    watch(20, ups);
    check("en0_updates", 32'(ups), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_stats_tracker.md
PULSE_STATS_TRACKER -- requirements
Module: pulse_stats_tracker

Interface
REQ-001 Parameter HIST_DEPTH, default 600: number of history points kept for max/min.
REQ-002 Parameter DIV_MAX, default 7: largest gain-divider shift honoured.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 en  in  1  block enable; 0 = synchronous clear of all state to reset values.
REQ-006 iPause  in  1  1 = ignore incoming samples and hold outputs; 0 = run.
REQ-007 iClear  in  1  single-cycle request: flush history and statistics.
REQ-008 iSample_Valid  in  1  single-cycle strobe marking a new raw pulse count.
REQ-009 iSample  in  32  raw pulse count.
REQ-010 iGain_Divider  in  8  right-shift amount applied to each sample.
REQ-011 oData_Update  out  1  one-cycle strobe; all outputs below are new and stable.
REQ-012 oPulse_Counter  out  32  latest scaled sample.
REQ-013 oPulseCounter_Accumulated  out  32  saturating sum of scaled samples since clear.
REQ-014 oMaxPulseCounter  out  16  maximum stored point over the history window.
REQ-015 oMinPulseCounter  out  16  minimum stored point over the history window.
REQ-016 oFill_Count  out  10  valid history entries, 0..HIST_DEPTH.
REQ-017 oBusy  out  1  1 while not in IDLE.
REQ-018 oOverrun  out  1  sticky; a sample was dropped.

Function
REQ-019 Scaled sample SHALL be iSample >> min(iGain_Divider, DIV_MAX), divider sampled in the accept cycle.
REQ-020 Stored point SHALL be the scaled sample saturated to 16'hFFFF.
REQ-021 Accumulator SHALL add the 32-bit scaled sample and clamp at 32'hFFFF_FFFF, never wrapping.
REQ-022 History SHALL be a ring: write pointer wraps HIST_DEPTH-1 -> 0; oFill_Count saturates at HIST_DEPTH; once full, the oldest point is overwritten.
REQ-023 FSM states: IDLE, WRITE, SCAN, PUBLISH.
REQ-024 IDLE -> WRITE when a sample is accepted (iSample_Valid, or a pending sample, with en=1 and iPause=0).
REQ-025 WRITE: store the point, advance the pointer, update oFill_Count and the accumulator; -> SCAN.
REQ-026 SCAN: read one entry per cycle, addresses 0..F-1 (F = fill after write); synchronous RAM with 1-cycle read latency; running max/min compared on returned data; -> PUBLISH after the last compare.
REQ-027 PUBLISH: register all outputs, pulse oData_Update for exactly one cycle; -> IDLE.
REQ-028 Latency: oData_Update high F+3 cycles after the accept cycle.
REQ-029 A sample arriving while oBusy=1 SHALL be held in a one-deep pending register and consumed on return to IDLE.
REQ-030 A sample arriving with the pending register full SHALL be dropped and set oOverrun; only iClear or reset clear oOverrun.
REQ-031 iPause=1: samples are neither accepted nor held; an in-progress WRITE/SCAN/PUBLISH completes normally.
REQ-032 iClear SHALL win in any state: abort, zero the pointer, fill, accumulator, max, min, pending and oOverrun; -> IDLE; no oData_Update. A coincident iSample_Valid is discarded.
REQ-033 With fill = 0: max = min = 0.
REQ-034 Outputs other than oData_Update SHALL change only in PUBLISH, on clear, or on en=0.

Reset
REQ-035 On rst_n=0: state IDLE; all outputs 0; pointer, fill, accumulator and pending register zero; RAM contents are don't-care because fill=0 masks them.
REQ-036 Reset or en=0 mid-scan SHALL abandon the scan with no oData_Update.

Structure
REQ-037 The shared package SHALL hold HIST_DEPTH, the address width (10), DIV_MAX and the FSM state encoding.
REQ-038 The history store SHALL be the sub-module pulse_hist_ram: HIST_DEPTH x 16 simple dual-port RAM, synchronous read.

Verification
REQ-039 Divider 2, samples 100, 40, 400 -> oPulse_Counter 100 after the last; accumulator 135; max 100; min 10.
REQ-040 601 samples of value k (k = 1..601), divider 0 -> fill 600; min 2 (value 1 overwritten); max 601; oData_Update 603 cycles after the last accept.
REQ-041 Sample 32'h0003_0000 with divider 0 -> stored point 16'hFFFF; accumulator pre-loaded near the top via repeated 32'hFFFF_FFFF samples -> clamps at 32'hFFFF_FFFF.
REQ-042 Three strobes on consecutive cycles -> first processed, second pending then processed, third dropped; oOverrun=1; exactly two oData_Update pulses.
REQ-043 iClear asserted mid-SCAN -> no oData_Update; all outputs 0 on the next cycle; the next sample gives fill 1.
REQ-044 iPause=1 with 5 strobes -> no update and outputs unchanged; after iPause=0, a new strobe gives fill +1.
